// File: rtl/alu_pkg.sv
// alu_pkg: shared types and sizing for the accumulator ALU.
//   SZER   - data / accumulator width
//   op_t   - 4-bit operation codes (0xB-0xF are unassigned and act as NOP)
//   stan_t - control FSM states
package alu_pkg;

  localparam int SZER = 8;

  typedef enum logic [3:0] {
    OP_LD  = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_NOT = 4'h6,
    OP_SHL = 4'h7,
    OP_SHR = 4'h8,
    OP_MUL = 4'h9,
    OP_ST  = 4'hA
  } op_t;

  typedef enum logic [1:0] {
    BEZCZYNNY = 2'd0,
    MNOZ      = 2'd1,
    GOTOWE    = 2'd2
  } stan_t;

endpackage

// File: rtl/mnozarka_iter.sv
// mnozarka_iter: iterative shift-add unsigned multiplier, one multiplier bit
// per clock, CYKLE (= SZER) iterations after the load edge.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - capture a/b and start; ignored while busy
//   a, b      - multiplicand, multiplier
//   busy      - high from the load edge until the last iteration edge
//   product   - running product including the current step's partial sum;
//               holds the full product in the cycle koniec is high
//   koniec    - high during the last iteration cycle
module mnozarka_iter #(
  parameter int SZER  = 8,
  parameter int CYKLE = SZER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [SZER-1:0]   a,
  input  logic [SZER-1:0]   b,
  output logic              busy,
  output logic [2*SZER-1:0] product,
  output logic              koniec
);

  localparam int CW = (CYKLE > 1) ? $clog2(CYKLE) : 1;
  localparam logic [CW-1:0] OSTATNI = CW'(CYKLE - 1);

  logic [2*SZER-1:0] mcand;
  logic [2*SZER-1:0] suma_q;
  logic [SZER-1:0]   mplier;
  logic [CW-1:0]     licznik;

  // Partial sum for this step is exposed combinationally so the consumer can
  // take the finished product on the very edge that ends the last iteration.
  always_comb begin
    product = suma_q;
    if (mplier[0]) product = suma_q + mcand;
  end

  assign koniec = busy && (licznik == OSTATNI);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      mcand   <= '0;
      suma_q  <= '0;
      mplier  <= '0;
      licznik <= '0;
    end else if (load && !busy) begin
      busy    <= 1'b1;
      mcand   <= {{SZER{1'b0}}, a};
      mplier  <= b;
      suma_q  <= '0;
      licznik <= '0;
    end else if (busy) begin
      suma_q  <= product;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      licznik <= licznik + 1'b1;
      if (koniec) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_akumulator.sv
// alu_akumulator: 8-bit ALU with accumulator feeding the flag register.
// Single-cycle ops complete one cycle after start; MUL runs on the
// iterative multiplier and completes nine cycles after start.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   start, op, operand   - request strobe, op code, second operand
//   busy                 - MUL in progress, start ignored
//   done                 - one-cycle completion pulse
//   acc_out              - accumulator
//   C_out, OV_out        - registered carry / signed overflow
//   P_out, Z_out, S_out  - even parity, zero, sign of acc_out
//   flagi_en, C_OV_en, C_OV_kasowanie - flag register strobes (done cycle only)
module alu_akumulator #(
  parameter int SZER      = alu_pkg::SZER,
  parameter int MUL_CYKLE = SZER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [SZER-1:0] operand,
  output logic            busy,
  output logic            done,
  output logic [SZER-1:0] acc_out,
  output logic            C_out,
  output logic            OV_out,
  output logic            P_out,
  output logic            Z_out,
  output logic            S_out,
  output logic            flagi_en,
  output logic            C_OV_en,
  output logic            C_OV_kasowanie
);
  import alu_pkg::*;

  localparam int M = SZER - 1;

  stan_t           stan;
  op_t             kod;
  logic [SZER-1:0] acc;
  logic            c_q, ov_q;

  logic [SZER-1:0] wynik;
  logic            c_nx, ov_nx, fl_en, cov_en, cov_kas;
  logic [SZER:0]   suma, roznica;

  logic              mul_busy, mul_koniec, mul_load;
  logic [2*SZER-1:0] mul_product;

  assign kod      = op_t'(op);
  assign mul_load = start && (stan != MNOZ) && (kod == OP_MUL);

  mnozarka_iter #(.SZER(SZER), .CYKLE(MUL_CYKLE)) u_mnozarka (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .a       (acc),
    .b       (operand),
    .busy    (mul_busy),
    .product (mul_product),
    .koniec  (mul_koniec)
  );

  assign suma    = {1'b0, acc} + {1'b0, operand};
  assign roznica = {1'b0, acc} - {1'b0, operand};

  // Result and flag source for every single-cycle op; MUL and NOPs keep state.
  always_comb begin
    wynik   = acc;
    c_nx    = c_q;
    ov_nx   = ov_q;
    fl_en   = 1'b0;
    cov_en  = 1'b0;
    cov_kas = 1'b0;
    case (kod)
      OP_LD: begin
        wynik = operand;
        fl_en = 1'b1;
      end
      OP_ADD: begin
        wynik  = suma[M:0];
        c_nx   = suma[SZER];
        ov_nx  = (acc[M] == operand[M]) && (suma[M] != acc[M]);
        fl_en  = 1'b1;
        cov_en = 1'b1;
      end
      OP_SUB: begin
        wynik  = roznica[M:0];
        c_nx   = roznica[SZER];  // borrow out == acc < operand
        ov_nx  = (acc[M] != operand[M]) && (roznica[M] != acc[M]);
        fl_en  = 1'b1;
        cov_en = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        case (kod)
          OP_AND:  wynik = acc & operand;
          OP_OR:   wynik = acc | operand;
          OP_XOR:  wynik = acc ^ operand;
          default: wynik = ~acc;
        endcase
        c_nx    = 1'b0;
        ov_nx   = 1'b0;
        fl_en   = 1'b1;
        cov_kas = 1'b1;
      end
      OP_SHL: begin
        wynik  = {acc[M-1:0], 1'b0};
        c_nx   = acc[M];
        ov_nx  = acc[M] ^ acc[M-1];
        fl_en  = 1'b1;
        cov_en = 1'b1;
      end
      OP_SHR: begin
        wynik  = {1'b0, acc[M:1]};
        c_nx   = acc[0];
        ov_nx  = 1'b0;
        fl_en  = 1'b1;
        cov_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stan           <= BEZCZYNNY;
      acc            <= '0;
      c_q            <= 1'b0;
      ov_q           <= 1'b0;
      done           <= 1'b0;
      flagi_en       <= 1'b0;
      C_OV_en        <= 1'b0;
      C_OV_kasowanie <= 1'b0;
    end else begin
      done           <= 1'b0;
      flagi_en       <= 1'b0;
      C_OV_en        <= 1'b0;
      C_OV_kasowanie <= 1'b0;
      case (stan)
        BEZCZYNNY, GOTOWE: begin
          if (!start) begin
            stan <= BEZCZYNNY;
          end else if (kod == OP_MUL) begin
            stan <= MNOZ;
          end else begin
            stan           <= GOTOWE;
            acc            <= wynik;
            c_q            <= c_nx;
            ov_q           <= ov_nx;
            done           <= 1'b1;
            flagi_en       <= fl_en;
            C_OV_en        <= cov_en;
            C_OV_kasowanie <= cov_kas;
          end
        end
        MNOZ: begin
          if (mul_koniec) begin
            stan     <= GOTOWE;
            acc      <= mul_product[M:0];
            c_q      <= |mul_product[2*SZER-1:SZER];
            ov_q     <= |mul_product[2*SZER-1:SZER];
            done     <= 1'b1;
            flagi_en <= 1'b1;
            C_OV_en  <= 1'b1;
          end
        end
        default: stan <= BEZCZYNNY;
      endcase
    end
  end

  assign busy    = mul_busy;
  assign acc_out = acc;
  assign C_out   = c_q;
  assign OV_out  = ov_q;
  assign P_out   = ~^acc;
  assign Z_out   = (acc == '0);
  assign S_out   = acc[M];

endmodule

// File: tb/tb_alu_akumulator.sv
// Directed bench for alu_akumulator with hand-computed expected values.
module tb_alu_akumulator;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] op;
  logic [7:0] operand;
  logic       busy, done, C_out, OV_out, P_out, Z_out, S_out;
  logic       flagi_en, C_OV_en, C_OV_kasowanie;
  logic [7:0] acc_out;

  int n_chk = 0;
  int n_err = 0;

  alu_akumulator #(.SZER(8), .MUL_CYKLE(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .op             (op),
    .operand        (operand),
    .busy           (busy),
    .done           (done),
    .acc_out        (acc_out),
    .C_out          (C_out),
    .OV_out         (OV_out),
    .P_out          (P_out),
    .Z_out          (Z_out),
    .S_out          (S_out),
    .flagi_en       (flagi_en),
    .C_OV_en        (C_OV_en),
    .C_OV_kasowanie (C_OV_kasowanie)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request for one clock; returns 1 time unit after the
  // accepting edge, i.e. inside the done cycle of a single-cycle op.
  task automatic issue(input logic [3:0] o, input logic [7:0] v);
    start   = 1'b1;
    op      = o;
    operand = v;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int k;
  int busy_cnt;
  int done_seen;

  initial begin
    rst = 1'b1; start = 1'b0; op = 4'h0; operand = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", 16'(acc_out), 16'h00);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_strobes", 16'({flagi_en, C_OV_en, C_OV_kasowanie}), 16'h0);
    chk("rst_Z", 16'(Z_out), 16'h1);
    chk("rst_P", 16'(P_out), 16'h1);
    rst = 1'b0;

    // LD 7F, ADD 01
    issue(4'(OP_LD), 8'h7F);
    chk("ld_done", 16'(done), 16'h1);
    chk("ld_acc", 16'(acc_out), 16'h7F);
    chk("ld_strobes", 16'({flagi_en, C_OV_en, C_OV_kasowanie}), 16'b100);
    tick();
    issue(4'(OP_ADD), 8'h01);
    chk("add_acc", 16'(acc_out), 16'h80);
    chk("add_C_OV", 16'({C_out, OV_out}), 16'b01);
    chk("add_SZP", 16'({S_out, Z_out, P_out}), 16'b100);
    chk("add_strobes", 16'({done, flagi_en, C_OV_en, C_OV_kasowanie}), 16'b1110);
    tick();
    chk("add_after", 16'({done, flagi_en, C_OV_en, C_OV_kasowanie}), 16'b0000);

    // LD 05, SUB 06 back to back, then AND 00
    issue(4'(OP_LD), 8'h05);
    issue(4'(OP_SUB), 8'h06);
    chk("sub_acc", 16'(acc_out), 16'hFF);
    chk("sub_C_OV", 16'({C_out, OV_out}), 16'b10);
    chk("sub_SP", 16'({S_out, P_out}), 16'b11);
    chk("sub_done", 16'(done), 16'h1);
    issue(4'(OP_AND), 8'h00);
    chk("and_acc", 16'(acc_out), 16'h00);
    chk("and_Z", 16'(Z_out), 16'h1);
    chk("and_strobes", 16'({flagi_en, C_OV_en, C_OV_kasowanie}), 16'b101);
    chk("and_C_OV", 16'({C_out, OV_out}), 16'b00);
    tick();

    // LD 10, MUL 11 = 0x110; a stray ADD during busy must be ignored
    issue(4'(OP_LD), 8'h10);
    issue(4'(OP_MUL), 8'h11);
    k = 1;
    busy_cnt = 0;
    while (!done && k < 20) begin
      if (busy) busy_cnt++;
      start   = (k == 3);
      op      = 4'(OP_ADD);
      operand = 8'h55;
      tick();
      k++;
    end
    start = 1'b0;
    chk("mul_latency", 16'(k), 16'd9);
    chk("mul_busy_cycles", 16'(busy_cnt), 16'd8);
    chk("mul_busy_at_done", 16'(busy), 16'h0);
    chk("mul_acc", 16'(acc_out), 16'h10);
    chk("mul_C_OV", 16'({C_out, OV_out}), 16'b11);
    chk("mul_strobes", 16'({flagi_en, C_OV_en, C_OV_kasowanie}), 16'b110);
    tick();
    chk("mul_after_acc", 16'(acc_out), 16'h10);
    chk("mul_after_done", 16'(done), 16'h0);

    // Shifts
    issue(4'(OP_LD), 8'h81);
    issue(4'(OP_SHL), 8'h00);
    chk("shl_acc", 16'(acc_out), 16'h02);
    chk("shl_C_OV", 16'({C_out, OV_out}), 16'b11);
    issue(4'(OP_SHR), 8'h00);
    chk("shr_acc", 16'(acc_out), 16'h01);
    chk("shr_C_OV", 16'({C_out, OV_out}), 16'b00);
    chk("shr_strobes", 16'({flagi_en, C_OV_en, C_OV_kasowanie}), 16'b110);
    tick();

    // LD after SHL keeps C/OV
    issue(4'(OP_LD), 8'h81);
    issue(4'(OP_SHL), 8'h00);
    issue(4'(OP_LD), 8'h3C);
    chk("ld_keeps_C_OV", 16'({C_out, OV_out}), 16'b11);
    tick();

    // ST and unassigned code behave as NOP with done
    issue(4'(OP_ST), 8'h33);
    chk("st_done", 16'(done), 16'h1);
    chk("st_acc", 16'(acc_out), 16'h3C);
    chk("st_strobes", 16'({flagi_en, C_OV_en, C_OV_kasowanie}), 16'b000);
    issue(4'hC, 8'h44);
    chk("nop_done", 16'(done), 16'h1);
    chk("nop_acc", 16'(acc_out), 16'h3C);
    chk("nop_strobes", 16'({flagi_en, C_OV_en, C_OV_kasowanie}), 16'b000);
    tick();

    // Reset during MUL aborts with no done
    issue(4'(OP_LD), 8'h03);
    issue(4'(OP_MUL), 8'h05);
    repeat (3) tick();
    chk("mid_mul_busy", 16'(busy), 16'h1);
    rst = 1'b1;
    tick();
    chk("abort_acc", 16'(acc_out), 16'h00);
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_done", 16'(done), 16'h0);
    tick();
    rst = 1'b0;
    chk("abort_strobes", 16'({flagi_en, C_OV_en, C_OV_kasowanie}), 16'b000);
    done_seen = 0;
    repeat (12) begin
      tick();
      if (done) done_seen++;
    end
    chk("abort_no_done", 16'(done_seen), 16'd0);
    chk("abort_acc_hold", 16'(acc_out), 16'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
